// File: rtl/signed_seq_divider_if.sv
// signed_seq_divider_if
//   Handshake and operand/result bundle for signed_seq_divider.
//   master : drives Start, Dividend, Divisor, Sign; observes results.
//   slave  : the divider side; drives Busy, Done, Quotient, Remainder,
//            Div_By_Zero.
//   Start        request a division (sampled only while idle)
//   Dividend     WIDTH-bit dividend
//   Divisor      WIDTH-bit divisor
//   Sign         1 = two's complement operands, 0 = unsigned
//   Busy         division in progress
//   Done         one-cycle pulse, results valid and held afterwards
//   Quotient     WIDTH-bit quotient, truncated toward zero
//   Remainder    WIDTH-bit remainder, sign of the dividend
//   Div_By_Zero  captured divisor was zero
interface signed_seq_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Start;
  logic [WIDTH-1:0] Dividend;
  logic [WIDTH-1:0] Divisor;
  logic             Sign;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Div_By_Zero;

  modport master (
    output Start, Dividend, Divisor, Sign,
    input  Busy, Done, Quotient, Remainder, Div_By_Zero
  );

  modport slave (
    input  Start, Dividend, Divisor, Sign,
    output Busy, Done, Quotient, Remainder, Div_By_Zero
  );
endinterface

// File: rtl/signed_seq_divider.sv
// signed_seq_divider
//   Multi-cycle restoring divider, one quotient bit per clock, for unsigned
//   or two's-complement operands. Operands are reduced to magnitudes on
//   acceptance, divided as unsigned values, and sign-corrected in FIX.
//   Ports:
//     Clk    rising-edge clock
//     Reset  synchronous active-high reset, aborts any running division
//     bus    signed_seq_divider_if.slave (start/busy/done handshake,
//            operands, results)
//   Sequence: IDLE -> CALC (WIDTH cycles) -> FIX -> DONE -> IDLE.
module signed_seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  signed_seq_divider_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [WIDTH-1:0] r_quo;      // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] r_dvs;      // divisor magnitude
  logic [CW-1:0]    r_cnt;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_qfix;
  logic [WIDTH-1:0] w_rfix;
  logic             w_busy;
  logic             w_done;

  // Negating the most-negative value yields 2^(WIDTH-1), which is exactly
  // its magnitude when read as unsigned, so no extra bit is needed here.
  always_comb begin
    w_dvd_mag = bus.Dividend;
    w_dvs_mag = bus.Divisor;
    if (bus.Sign && bus.Dividend[WIDTH-1]) w_dvd_mag = '0 - bus.Dividend;
    if (bus.Sign && bus.Divisor[WIDTH-1])  w_dvs_mag = '0 - bus.Divisor;
  end

  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the subtractor's top bit is a clean borrow flag.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[WIDTH];

  assign w_qfix = r_qneg ? ('0 - r_quo) : r_quo;
  assign w_rfix = r_rneg ? ('0 - r_rem) : r_rem;

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.Start) w_next = S_CALC;
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (r_cnt == '0) w_next = S_FIX;
      end
      S_FIX: begin
        w_busy = 1'b1;
        w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_rem  <= '0;
            r_quo  <= w_dvd_mag;
            r_dvs  <= w_dvs_mag;
            r_cnt  <= CW'(WIDTH - 1);
            r_qneg <= bus.Sign & (bus.Dividend[WIDTH-1] ^ bus.Divisor[WIDTH-1]);
            r_rneg <= bus.Sign & bus.Dividend[WIDTH-1];
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_quotient  <= w_qfix;
          r_remainder <= w_rfix;
          r_dbz       <= (r_dvs == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy        = w_busy;
  assign bus.Done        = w_done;
  assign bus.Quotient    = r_quotient;
  assign bus.Remainder   = r_remainder;
  assign bus.Div_By_Zero = r_dbz;

endmodule

// File: tb/tb_signed_seq_divider.sv
// tb_signed_seq_divider
//   Directed checks of signed_seq_divider (WIDTH=8) plus a bounded random
//   sweep against a behavioural reference built on integer division.
module tb_signed_seq_divider;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  signed_seq_divider_if #(.WIDTH(8)) bus ();

  signed_seq_divider #(.WIDTH(8)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request and returns the number of rising edges from the
  // accepting edge to the first edge at which Done is sampled high
  // (0 when Done never appears within the bound).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int lat);
    @(negedge clk);
    bus.Dividend = a;
    bus.Divisor  = b;
    bus.Sign     = s;
    bus.Start    = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (bus.Done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic ref_div(input logic [7:0] a, input logic [7:0] b, input logic s,
                         output logic [7:0] q, output logic [7:0] r);
    int sa;
    int sb;
    if (!s) begin
      if (b == 8'd0) begin q = 8'hFF; r = a; end
      else begin q = a / b; r = a % b; end
    end else begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      if (sb == 0) begin
        q = (sa < 0) ? 8'h01 : 8'hFF;
        r = a;
      end else begin
        q = 8'(sa / sb);
        r = 8'(sa % sb);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.Start = 1'b0; bus.Dividend = 8'h00; bus.Divisor = 8'h00; bus.Sign = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.Busy); end
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.Done); end
    checks++; if (bus.Quotient !== 8'h00) begin errors++; $display("FAIL reset_quo: got %h expected 00", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'h00) begin errors++; $display("FAIL reset_rem: got %h expected 00", bus.Remainder); end
    checks++; if (bus.Div_By_Zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", bus.Div_By_Zero); end
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    int lat;
    run_op(8'd200, 8'd7, 1'b0, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL unsigned_latency: got %0d expected 10", lat); end
    checks++; if (bus.Quotient !== 8'd28) begin errors++; $display("FAIL unsigned_quo: got %0d expected 28", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'd4) begin errors++; $display("FAIL unsigned_rem: got %0d expected 4", bus.Remainder); end
    checks++; if (bus.Div_By_Zero !== 1'b0) begin errors++; $display("FAIL unsigned_dbz: got %b expected 0", bus.Div_By_Zero); end
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL done_cycle_busy: got %b expected 0", bus.Busy); end
    // results held after the Done pulse
    @(negedge clk);
    checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL done_single_pulse: got %b expected 0", bus.Done); end
    checks++; if (bus.Quotient !== 8'd28) begin errors++; $display("FAIL unsigned_quo_held: got %0d expected 28", bus.Quotient); end
  endtask

  task automatic test_signed();
    int lat;
    run_op(8'hF9, 8'h02, 1'b1, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL signed1_latency: got %0d expected 10", lat); end
    checks++; if (bus.Quotient !== 8'hFD) begin errors++; $display("FAIL signed1_quo: got %h expected fd", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'hFF) begin errors++; $display("FAIL signed1_rem: got %h expected ff", bus.Remainder); end
    run_op(8'h07, 8'hFE, 1'b1, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL signed2_latency: got %0d expected 10", lat); end
    checks++; if (bus.Quotient !== 8'hFD) begin errors++; $display("FAIL signed2_quo: got %h expected fd", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'h01) begin errors++; $display("FAIL signed2_rem: got %h expected 01", bus.Remainder); end
    // -20 / -6 = 3 r -2
    run_op(8'hEC, 8'hFA, 1'b1, lat);
    checks++; if (bus.Quotient !== 8'h03) begin errors++; $display("FAIL signed3_quo: got %h expected 03", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'hFE) begin errors++; $display("FAIL signed3_rem: got %h expected fe", bus.Remainder); end
  endtask

  task automatic test_div_zero();
    int lat;
    run_op(8'd55, 8'd0, 1'b0, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL dbz_latency: got %0d expected 10", lat); end
    checks++; if (bus.Quotient !== 8'hFF) begin errors++; $display("FAIL dbz_quo: got %h expected ff", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'd55) begin errors++; $display("FAIL dbz_rem: got %0d expected 55", bus.Remainder); end
    checks++; if (bus.Div_By_Zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", bus.Div_By_Zero); end
    @(negedge clk);
    checks++; if (bus.Div_By_Zero !== 1'b1) begin errors++; $display("FAIL dbz_flag_held: got %b expected 1", bus.Div_By_Zero); end
    run_op(8'd9, 8'd3, 1'b0, lat);
    checks++; if (bus.Quotient !== 8'd3) begin errors++; $display("FAIL after_dbz_quo: got %0d expected 3", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'd0) begin errors++; $display("FAIL after_dbz_rem: got %0d expected 0", bus.Remainder); end
    checks++; if (bus.Div_By_Zero !== 1'b0) begin errors++; $display("FAIL after_dbz_flag: got %b expected 0", bus.Div_By_Zero); end
    // signed: -5 / 0 -> +1, remainder -5
    run_op(8'hFB, 8'h00, 1'b1, lat);
    checks++; if (bus.Quotient !== 8'h01) begin errors++; $display("FAIL sdbz_neg_quo: got %h expected 01", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'hFB) begin errors++; $display("FAIL sdbz_neg_rem: got %h expected fb", bus.Remainder); end
    checks++; if (bus.Div_By_Zero !== 1'b1) begin errors++; $display("FAIL sdbz_neg_flag: got %b expected 1", bus.Div_By_Zero); end
    // signed: 5 / 0 -> -1, remainder 5
    run_op(8'h05, 8'h00, 1'b1, lat);
    checks++; if (bus.Quotient !== 8'hFF) begin errors++; $display("FAIL sdbz_pos_quo: got %h expected ff", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'h05) begin errors++; $display("FAIL sdbz_pos_rem: got %h expected 05", bus.Remainder); end
  endtask

  task automatic test_boundaries();
    int lat;
    run_op(8'h80, 8'hFF, 1'b1, lat);
    checks++; if (bus.Quotient !== 8'h80) begin errors++; $display("FAIL ovf_quo: got %h expected 80", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'h00) begin errors++; $display("FAIL ovf_rem: got %h expected 00", bus.Remainder); end
    checks++; if (bus.Div_By_Zero !== 1'b0) begin errors++; $display("FAIL ovf_flag: got %b expected 0", bus.Div_By_Zero); end
    run_op(8'h80, 8'h01, 1'b1, lat);
    checks++; if (bus.Quotient !== 8'h80) begin errors++; $display("FAIL minneg_by1_quo: got %h expected 80", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'h00) begin errors++; $display("FAIL minneg_by1_rem: got %h expected 00", bus.Remainder); end
    run_op(8'd255, 8'd255, 1'b0, lat);
    checks++; if (bus.Quotient !== 8'd1) begin errors++; $display("FAIL max_by_max_quo: got %0d expected 1", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'd0) begin errors++; $display("FAIL max_by_max_rem: got %0d expected 0", bus.Remainder); end
    run_op(8'd3, 8'd200, 1'b0, lat);
    checks++; if (bus.Quotient !== 8'd0) begin errors++; $display("FAIL small_by_big_quo: got %0d expected 0", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'd3) begin errors++; $display("FAIL small_by_big_rem: got %0d expected 3", bus.Remainder); end
  endtask

  task automatic test_handshake();
    int pulses;
    int busy_seen;
    pulses = 0;
    busy_seen = 0;
    @(negedge clk);
    bus.Dividend = 8'd100; bus.Divisor = 8'd7; bus.Sign = 1'b0; bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (3) @(negedge clk);
    if (bus.Busy === 1'b1) busy_seen = 1;
    bus.Dividend = 8'd50; bus.Divisor = 8'd5; bus.Sign = 1'b1; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (bus.Done === 1'b1) break;
      @(negedge clk);
    end
    checks++; if (busy_seen !== 1) begin errors++; $display("FAIL hs_busy_in_calc: got %0d expected 1", busy_seen); end
    checks++; if (bus.Done !== 1'b1) begin errors++; $display("FAIL hs_done_seen: got %b expected 1", bus.Done); end
    checks++; if (bus.Quotient !== 8'd14) begin errors++; $display("FAIL hs_quo: got %0d expected 14", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'd2) begin errors++; $display("FAIL hs_rem: got %0d expected 2", bus.Remainder); end
    pulses = 1;
    // Start during the DONE cycle must not begin another division
    bus.Dividend = 8'd60; bus.Divisor = 8'd6; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    for (int n = 0; n < 15; n++) begin
      if (bus.Done === 1'b1) pulses++;
      if (bus.Busy === 1'b1) busy_seen = 2;
      @(negedge clk);
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL hs_done_pulses: got %0d expected 1", pulses); end
    checks++; if (busy_seen !== 1) begin errors++; $display("FAIL hs_no_restart: got busy marker %0d expected 1", busy_seen); end
    checks++; if (bus.Quotient !== 8'd14) begin errors++; $display("FAIL hs_quo_held: got %0d expected 14", bus.Quotient); end
  endtask

  task automatic test_back_to_back();
    int idx[$];
    @(negedge clk);
    bus.Dividend = 8'd20; bus.Divisor = 8'd4; bus.Sign = 1'b0; bus.Start = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) idx.push_back(n);
    end
    bus.Start = 1'b0;
    checks++; if (idx.size() !== 4) begin errors++; $display("FAIL b2b_count: got %0d expected 4", idx.size()); end
    if (idx.size() >= 2) begin
      checks++; if (idx[0] !== 10) begin errors++; $display("FAIL b2b_first: got %0d expected 10", idx[0]); end
      for (int i = 1; i < idx.size(); i++) begin
        checks++;
        if (idx[i] - idx[i-1] !== 11) begin
          errors++; $display("FAIL b2b_interval: got %0d expected 11", idx[i] - idx[i-1]);
        end
      end
    end
    checks++; if (bus.Quotient !== 8'd5) begin errors++; $display("FAIL b2b_quo: got %0d expected 5", bus.Quotient); end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int done_seen;
    int lat;
    done_seen = 0;
    @(negedge clk);
    bus.Dividend = 8'd77; bus.Divisor = 8'd5; bus.Sign = 1'b0; bus.Start = 1'b1;
    @(posedge clk);
    #1 bus.Start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", bus.Busy); end
    checks++; if (bus.Quotient !== 8'h00) begin errors++; $display("FAIL rmid_quo: got %h expected 00", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'h00) begin errors++; $display("FAIL rmid_rem: got %h expected 00", bus.Remainder); end
    checks++; if (bus.Div_By_Zero !== 1'b0) begin errors++; $display("FAIL rmid_dbz: got %b expected 0", bus.Div_By_Zero); end
    for (int n = 0; n < 15; n++) begin
      if (bus.Done === 1'b1) done_seen = 1;
      @(negedge clk);
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d expected 0", done_seen); end
    run_op(8'd100, 8'd9, 1'b0, lat);
    checks++; if (lat !== 10) begin errors++; $display("FAIL rmid_fresh_latency: got %0d expected 10", lat); end
    checks++; if (bus.Quotient !== 8'd11) begin errors++; $display("FAIL rmid_fresh_quo: got %0d expected 11", bus.Quotient); end
    checks++; if (bus.Remainder !== 8'd1) begin errors++; $display("FAIL rmid_fresh_rem: got %0d expected 1", bus.Remainder); end
  endtask

  task automatic test_random();
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] eq;
    logic [7:0] er;
    logic       s;
    int         lat;
    for (int i = 0; i < 3000; i++) begin
      a = 8'($urandom);
      b = (i % 50 == 0) ? 8'd0 : 8'($urandom);
      s = (i % 2 == 1);
      ref_div(a, b, s, eq, er);
      run_op(a, b, s, lat);
      checks++;
      if (lat !== 10 || bus.Quotient !== eq || bus.Remainder !== er ||
          bus.Div_By_Zero !== (b == 8'd0)) begin
        errors++;
        $display("FAIL random a=%h b=%h s=%b: got q=%h r=%h dbz=%b lat=%0d expected q=%h r=%h dbz=%b lat=10",
                 a, b, s, bus.Quotient, bus.Remainder, bus.Div_By_Zero, lat, eq, er, (b == 8'd0));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_boundaries();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
